// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM encodings, slave
// register map, default build-time expected words and the status record.
package sysid_pkg;

    typedef logic [2:0] sysid_state_t;

    localparam sysid_state_t ST_IDLE  = 3'd0;
    localparam sysid_state_t ST_RD_ID = 3'd1;
    localparam sysid_state_t ST_RD_TS = 3'd2;
    localparam sysid_state_t ST_CHECK = 3'd3;
    localparam sysid_state_t ST_DONE  = 3'd4;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5A23_4ACF;

    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
    } sysid_status_t;

    function automatic logic sysid_is_busy(input sysid_state_t s);
        return (s == ST_RD_ID) || (s == ST_RD_TS) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/sysid_boot_checker.sv
// Boot-time checker: reads the sysid ID and timestamp words over Avalon-MM,
// compares them with build-time values, retries on mismatch, guards stalls.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] id_read,
    output logic [31:0] ts_read,
    output logic [3:0]  retries
);

    localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRIES);

    sysid_state_t        state_reg, state_next;
    logic                auto_pending_reg;
    logic [STALL_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [31:0]         id_read_reg, id_read_next;
    logic [31:0]         ts_read_reg, ts_read_next;
    logic [3:0]          retries_reg, retries_next;
    sysid_status_t       status_reg, status_next;

    logic                launch;
    logic                in_read;
    logic [31:0]         captured [2];
    logic [1:0]          word_match;

    assign captured[0] = id_read_reg;
    assign captured[1] = ts_read_reg;

    // Compare only registered captures so status never depends combinationally on readdata.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            localparam logic [31:0] EXP_WORD = (gi == 0) ? EXPECTED_ID : EXPECTED_TS;
            assign word_match[gi] = (captured[gi] == EXP_WORD);
        end
    endgenerate

    assign in_read = (state_reg == ST_RD_ID) || (state_reg == ST_RD_TS);

    always_comb begin
        state_next     = state_reg;
        stall_cnt_next = stall_cnt_reg;
        id_read_next   = id_read_reg;
        ts_read_next   = ts_read_reg;
        retries_next   = retries_reg;
        status_next    = status_reg;
        launch         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                launch = auto_pending_reg || start;
            end
            ST_RD_ID, ST_RD_TS: begin
                if (avm_waitrequest) begin
                    // Stalled too long: abandon the check without retrying.
                    if (stall_cnt_reg == STALL_LIMIT) begin
                        state_next          = ST_DONE;
                        status_next.timeout = 1'b1;
                        status_next.fail    = 1'b1;
                    end else begin
                        stall_cnt_next = stall_cnt_reg + 1'b1;
                    end
                end else begin
                    stall_cnt_next = '0;
                    if (state_reg == ST_RD_ID) begin
                        id_read_next = avm_readdata;
                        state_next   = ST_RD_TS;
                    end else begin
                        ts_read_next = avm_readdata;
                        state_next   = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (&word_match) begin
                    state_next       = ST_DONE;
                    status_next.pass = 1'b1;
                end else if (retries_reg < RETRY_LIMIT) begin
                    retries_next   = retries_reg + 4'd1;
                    stall_cnt_next = '0;
                    state_next     = ST_RD_ID;
                end else begin
                    state_next       = ST_DONE;
                    status_next.fail = 1'b1;
                end
            end
            ST_DONE: begin
                launch = start;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_next     = ST_RD_ID;
            stall_cnt_next = '0;
            retries_next   = '0;
            status_next    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            auto_pending_reg <= AUTO_START;
            stall_cnt_reg    <= '0;
            id_read_reg      <= '0;
            ts_read_reg      <= '0;
            retries_reg      <= '0;
            status_reg       <= '0;
        end else begin
            state_reg        <= state_next;
            auto_pending_reg <= 1'b0;
            stall_cnt_reg    <= stall_cnt_next;
            id_read_reg      <= id_read_next;
            ts_read_reg      <= ts_read_next;
            retries_reg      <= retries_next;
            status_reg       <= status_next;
        end
    end

    // Strobe and address come straight from the state register, so they stay put during stalls.
    assign avm_read    = in_read;
    assign avm_address = (state_reg == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = sysid_is_busy(state_reg);
    assign done        = (state_reg == ST_DONE);
    assign pass        = status_reg.pass;
    assign fail        = status_reg.fail;
    assign timeout     = status_reg.timeout;
    assign id_read     = id_read_reg;
    assign ts_read     = ts_read_reg;
    assign retries     = retries_reg;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: behavioural sysid slave plus a
// scoreboard of expected check outcomes.
module tb_sysid_boot_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] id_read, ts_read;
    logic [3:0]  retries;

    always #5 clock = ~clock;

    sysid_boot_checker #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (32'h5A23_4ACF),
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (3),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail            (fail),
        .timeout         (timeout),
        .id_read         (id_read),
        .ts_read         (ts_read),
        .retries         (retries)
    );

    // Slave configuration, owned by the stimulus block.
    bit stuck      = 1'b0;
    int wait_n     = 0;
    int bad_passes = 0;
    int ts_base    = 0;

    // Slave and monitor state, owned by the clocked process.
    int ts_total  = 0;
    int stall_cnt = 0;
    int rd_total  = 0;
    int stab_err  = 0;
    bit prev_stall = 1'b0;
    logic prev_addr = 1'b0;

    always_comb begin
        avm_waitrequest = stuck || (avm_read && (stall_cnt < wait_n));
        if (avm_address)
            avm_readdata = ((ts_total - ts_base) < bad_passes) ? 32'hDEAD_BEEF : 32'h5A23_4ACF;
        else
            avm_readdata = 32'h0000_0000;
    end

    always @(posedge clock) begin
        if (!avm_read || reset) stall_cnt <= 0;
        else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (avm_read && avm_address && !avm_waitrequest && !reset) ts_total <= ts_total + 1;
        if (avm_read) rd_total <= rd_total + 1;
        if (prev_stall && (!avm_read || avm_address !== prev_addr)) stab_err <= stab_err + 1;
        prev_stall <= avm_read && avm_waitrequest && !stuck && !reset;
        prev_addr  <= avm_address;
    end

    typedef struct {
        int          lat;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [3:0]  retries;
        logic [31:0] id;
        logic [31:0] ts;
        int          rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, busy, done, pass, fail, timeout, avm_read, avm_address},
            32'd0);
        chk({tag, "_retries"}, {28'd0, retries}, 32'd0);
        chk({tag, "_id"}, id_read, 32'd0);
        chk({tag, "_ts"}, ts_read, 32'd0);
    endtask

    // Launches a check (reset release or start pulse), counts cycles to done, scores the result.
    task automatic run_check(input bit use_reset, input int pulse_at);
        int   lat;
        int   rd_base;
        exp_t e;
        if (use_reset) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
        end else begin
            start = 1'b1;
        end
        rd_base = rd_total;
        lat = 0;
        while (1) begin
            @(posedge clock); #1;
            lat++;
            start = (lat == pulse_at);
            if (done || lat >= 200) break;
        end
        start = 1'b0;
        txn++;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_latency", lat, e.lat);
            chk("done", {31'd0, done}, 32'd1);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            chk("pass", {31'd0, pass}, {31'd0, e.pass});
            chk("fail", {31'd0, fail}, {31'd0, e.fail});
            chk("timeout", {31'd0, timeout}, {31'd0, e.tmo});
            chk("retries", {28'd0, retries}, {28'd0, e.retries});
            chk("id_read", id_read, e.id);
            chk("ts_read", ts_read, e.ts);
            chk("read_cycles", rd_total - rd_base, e.rd);
            chk("read_dropped", {31'd0, avm_read}, 32'd0);
            chk("addr_stable", stab_err, 32'd0);
        end
        $display("txn %0d: latency=%0d pass=%0b fail=%0b timeout=%0b retries=%0d id=%h ts=%h",
                 txn, lat, pass, fail, timeout, retries, id_read, ts_read);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");

        // Zero-wait, correct words, automatic start.
        sb.push_back('{4, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h5A23_4ACF, 2});
        run_check(1'b1, -1);

        // Two bad timestamp passes, then good.
        ts_base = ts_total; bad_passes = 2;
        sb.push_back('{10, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0, 32'h5A23_4ACF, 6});
        run_check(1'b0, -1);

        // Timestamp never matches: retries exhausted.
        ts_base = ts_total; bad_passes = 100;
        sb.push_back('{13, 1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 8});
        run_check(1'b0, -1);

        // Reset while the timestamp read is in flight.
        ts_base = ts_total; bad_passes = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!(avm_read && avm_address) && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("reached_rd_ts", {31'd0, avm_read && avm_address}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk_zero("mid_reset");
        sb.push_back('{4, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h5A23_4ACF, 2});
        run_check(1'b1, -1);

        // Two wait cycles per read, stray start during the timestamp read.
        wait_n = 2;
        sb.push_back('{8, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h5A23_4ACF, 6});
        run_check(1'b0, 5);

        // Waitrequest stuck high on the ID read.
        wait_n = 0; stuck = 1'b1;
        sb.push_back('{9, 1'b0, 1'b1, 1'b1, 4'd0, 32'h0, 32'h0, 8});
        run_check(1'b1, -1);

        // Start from DONE clears the timeout status and reruns.
        stuck = 1'b0;
        sb.push_back('{4, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h5A23_4ACF, 2});
        run_check(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Boot-time controller for the system-ID slave: after reset (or on request) it sequences Avalon-MM reads of the ID word (address 0) and timestamp word (address 1), and compares both against build-time expected values. It retries on mismatch and guards each read with a timeout. It publishes a sticky pass/fail/timeout status for the Nios software and the board LEDs. It sits in the SoC between the interconnect master port and the `sysid` control slave.

## Interface
- `EXPECTED_ID`, 32'h0000_0000, expected word at address 0
- `EXPECTED_TS`, 32'h5A23_4ACF, expected word at address 1
- `TIMEOUT_CYCLES`, 256, max cycles a read may stall on waitrequest (≥2)
- `MAX_RETRIES`, 3, extra full read passes after a mismatch (0..15)
- `AUTO_START`, 1, start a check automatically after reset

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to (re)run the check
- `avm_address`  out  1  0 = ID, 1 = timestamp
- `avm_read`  out  1  read strobe
- `avm_readdata`  in  32  read data
- `avm_waitrequest`  in  1  slave stall; tie 0 for zero-wait sysid
- `busy`  out  1  check in progress
- `done`  out  1  level; result valid
- `pass`  out  1  both words matched
- `fail`  out  1  mismatch after all retries, or timeout
- `timeout`  out  1  a read stalled ≥ TIMEOUT_CYCLES
- `id_read`  out  32  last captured ID word
- `ts_read`  out  32  last captured timestamp word
- `retries`  out  4  retry passes used in the last check

## Operation
- FSM states: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE: if `AUTO_START` and first cycle after reset, or `start`=1 → RD_ID. Clears `done/pass/fail/timeout/retries` on entry to RD_ID from IDLE/DONE.
- RD_ID: `avm_read`=1, `avm_address`=0. If `avm_waitrequest`=0: capture `avm_readdata` into `id_read`, → RD_TS.
- RD_TS: same with address 1, capture into `ts_read`, → CHECK.
- CHECK: one cycle. Both match → DONE with `pass`=1. Mismatch and retry count < MAX_RETRIES → increment count, → RD_ID. Otherwise → DONE with `fail`=1.
- Timeout: a per-read stall counter clears on entering each read state and increments each cycle `avm_waitrequest`=1. At count = TIMEOUT_CYCLES−1 with waitrequest still high → DONE, `timeout`=1, `fail`=1, `avm_read` dropped the same cycle. Timeout is not retried.
- DONE: status held. `start`=1 → RD_ID (new check). `start` in RD_ID/RD_TS/CHECK is ignored.
- `busy` = state ∈ {RD_ID, RD_TS, CHECK}. `done` = state is DONE.
- `avm_address`/`avm_read` are held stable while waitrequest=1.

## Timing
- Reset values: all outputs 0; `id_read`/`ts_read` = 0; state IDLE.
- Reset mid-check: read aborted next edge, all outputs 0. With AUTO_START=1 a fresh check begins the first cycle after `reset` deasserts.
- Zero-wait latency: `start` sampled at edge 0 → RD_ID cycle 1, RD_TS cycle 2, CHECK cycle 3, `done` high cycle 4. Each retry adds 3 cycles.
- Each wait cycle adds 1 cycle to its read.
- Outputs are registered (state-decoded); no combinational path from `avm_readdata` to status.

## Structure
- Shared package `sysid_pkg`: state enum, `SYSID_ADDR_ID`=0, `SYSID_ADDR_TS`=1, default expected constants.
- No sub-module needed; the stall counter is inline.

## Test plan
- Zero-wait slave returning 0 / 0x5A234ACF, AUTO_START=1 → `done` at cycle 4 after reset release, `pass`=1, `retries`=0, `ts_read`=0x5A234ACF.
- Slave returns wrong TS for first 2 passes, then correct; MAX_RETRIES=3 → `pass`=1, `retries`=2, `done` at cycle 10.
- Slave always returns TS 0xDEADBEEF → `fail`=1, `timeout`=0, `retries`=3, `done` at cycle 13.
- waitrequest stuck high on ID read, TIMEOUT_CYCLES=8 → `avm_read` low after 8 read cycles; `timeout`=1, `fail`=1, `id_read`=0.
- 2 wait cycles on each read → address/read stable during stalls, `pass`=1, `done` at cycle 8. `start` pulsed in RD_TS is ignored. `start` in DONE reruns the check and clears status.
- `reset` asserted in RD_TS → all outputs 0 next cycle, then a clean rerun to `pass`.
